// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x480@60 porch/sync timing and framebuffer widths.
package vga_pkg;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = 640 + H_FP + H_SYNC + H_BP;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = 480 + V_FP + V_SYNC + V_BP;
  localparam int ADDR_W  = 19;
  localparam int PIX_W   = 8;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, h/v scan counters and raw sync/active flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       active_o
);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [9:0] HA       = 10'(H_ACTIVE);
  localparam logic [9:0] VA       = 10'(V_ACTIVE);
  localparam logic [9:0] HS0      = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1      = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0      = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1      = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       run_q, div_end, h_end, v_end;

  assign div_end = div_q == DIV_LAST;
  assign h_end   = h_q == H_LAST;
  assign v_end   = v_q == V_LAST;
  // run_q keeps the tick low during reset even when CLK_DIV is 1
  assign tick_o    = run_q && div_end;
  assign h_o       = h_q;
  assign v_o       = v_q;
  assign hsync_n_o = !(h_q >= HS0 && h_q < HS1);
  assign vsync_n_o = !(v_q >= VS0 && v_q < VS1);
  assign active_o  = h_q < HA && v_q < VA;

  always_comb begin
    div_d = div_end ? '0 : div_q + 2'd1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick_o) begin
      h_d = h_end ? '0 : h_q + 10'd1;
      v_d = !h_end ? v_q : v_end ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q <= '0;
      run_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      run_q <= 1'b1;
      h_q   <= h_d;
      v_q   <= v_d;
    end
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans the grayscale framebuffer and shows it centred on 640x480@60 VGA.
// Optional macro TEST_PATTERN_EN adds test_mode, swapping RAM colour for an h[9:2] gradient.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              img_valid,
  input  logic [9:0]        img_width,
  input  logic [8:0]        img_height,
`ifdef TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [PIX_W-1:0]  ram_rd_data,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic              vga_pix_tick,
  output logic [PIX_W-1:0]  vga_r,
  output logic [PIX_W-1:0]  vga_g,
  output logic [PIX_W-1:0]  vga_b,
  output logic              frame_start
);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [8:0] VA = 9'(V_ACTIVE);

  logic              tick, hs_raw, vs_raw, act, win;
  logic [9:0]        h, v;
  logic [9:0]        w_d, x0_d, w_q, x0_q, cw, cx;
  logic [8:0]        hg_d, y0_d, hg_q, y0_q, ch, cy;
  logic              show_d, show_q, cs;
  logic [ADDR_W-1:0] cnt_q, addr_q, base;
  logic              win1_q, blank1_q, hs1_q, vs1_q, blank_q, hs_q, vs_q;
  logic [PIX_W-1:0]  pix_q, pix_src;

  vga_timing_gen #(.CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_tg (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_o   (tick),
    .h_o      (h),
    .v_o      (v),
    .hsync_n_o(hs_raw),
    .vsync_n_o(vs_raw),
    .active_o (act)
  );

  assign frame_start = tick && h == '0 && v == '0;

  always_comb begin
    w_d    = img_width > HA ? HA : img_width;
    hg_d   = img_height > VA ? VA : img_height;
    x0_d   = (HA - w_d) >> 1;
    y0_d   = (VA - hg_d) >> 1;
    show_d = img_valid && w_d != '0 && hg_d != '0;
  end

  // Pixel (0,0) is judged against the geometry being latched on that same tick
  assign cw   = frame_start ? w_d : w_q;
  assign cx   = frame_start ? x0_d : x0_q;
  assign ch   = frame_start ? hg_d : hg_q;
  assign cy   = frame_start ? y0_d : y0_q;
  assign cs   = frame_start ? show_d : show_q;
  assign win  = cs && h >= cx && h < cx + cw && v >= {1'b0, cy} && v < {1'b0, cy + ch};
  assign base = frame_start ? '0 : cnt_q;

`ifdef TEST_PATTERN_EN
  logic             tm_q;
  logic [PIX_W-1:0] grad1_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tm_q    <= 1'b0;
      grad1_q <= '0;
    end else if (tick) begin
      if (frame_start) tm_q <= test_mode;
      grad1_q <= h[9:2];
    end
  assign pix_src = tm_q ? grad1_q : ram_rd_data;
`else
  assign pix_src = ram_rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_q      <= '0;
      x0_q     <= '0;
      hg_q     <= '0;
      y0_q     <= '0;
      show_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      win1_q   <= 1'b0;
      blank1_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      pix_q    <= '0;
      blank_q  <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else if (tick) begin
      if (frame_start) begin
        w_q    <= w_d;
        x0_q   <= x0_d;
        hg_q   <= hg_d;
        y0_q   <= y0_d;
        show_q <= show_d;
      end
      if (win) addr_q <= base;
      cnt_q    <= win ? base + ADDR_W'(1) : base;
      win1_q   <= win;
      blank1_q <= act;
      hs1_q    <= hs_raw;
      vs1_q    <= vs_raw;
      pix_q    <= win1_q ? pix_src : '0;
      blank_q  <= blank1_q;
      hs_q     <= hs1_q;
      vs_q     <= vs1_q;
    end

  assign ram_rd_addr = addr_q;
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;
  assign vga_blank_n = blank_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_pix_tick = tick;
endmodule
